instr_fetch: RTL and testbench

- Fetch stage directly upstream of the instruction ROM.
- Holds the program counter and drives the ROM word address; the ROM answers combinationally.
- Registers the returned instruction plus its PC into an IF/ID pipeline register with a valid/ready handshake toward decode.
- Accepts branch/jump redirects from execute and halts on a misaligned target.

---
 rtl/instr_fetch.sv | 143 ++++++++++++++
 tb/tb_instr_fetch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ROM_AW   = 8,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [XLEN-1:0]   rom_data,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_instr,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_pc_plus4,
    output logic              fault,
    output logic [XLEN-1:0]   fault_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_bubbles
`endif
);

    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_instr_q, out_instr_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [XLEN-1:0]   out_pc_plus4_q, out_pc_plus4_d;
    logic              fault_q, fault_d;
    logic [XLEN-1:0]   fault_pc_q, fault_pc_d;

    assign rom_addr     = pc_q[ROM_AW+1:2];
    assign out_valid    = out_valid_q;
    assign out_instr    = out_instr_q;
    assign out_pc       = out_pc_q;
    assign out_pc_plus4 = out_pc_plus4_q;
    assign fault        = fault_q;
    assign fault_pc     = fault_pc_q;

    // Next-state: misaligned redirect > aligned redirect > advance > stall.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_pc_d       = out_pc_q;
        out_pc_plus4_d = out_pc_plus4_q;
        fault_d        = fault_q;
        fault_pc_d     = fault_pc_q;

        if (state_q == ST_HALT) begin
            out_valid_d = 1'b0;
            fault_d     = 1'b1;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            state_d     = ST_HALT;
            fault_d     = 1'b1;
            fault_pc_d  = redirect_pc;
            out_valid_d = 1'b0;
        end else if (redirect_valid) begin
            // The ROM word fetched this cycle is wrong-path and is dropped.
            pc_d        = redirect_pc;
            out_valid_d = 1'b0;
            out_instr_d = NOP;
        end else if (!out_valid_q || out_ready) begin
            out_instr_d    = rom_data;
            out_pc_d       = pc_q;
            out_pc_plus4_d = pc_q + FOUR;
            out_valid_d    = 1'b1;
            pc_d           = pc_q + FOUR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            pc_q           <= RESET_PC;
            out_valid_q    <= 1'b0;
            out_instr_q    <= NOP;
            out_pc_q       <= '0;
            out_pc_plus4_q <= '0;
            fault_q        <= 1'b0;
            fault_pc_q     <= '0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_pc_q       <= out_pc_d;
            out_pc_plus4_q <= out_pc_plus4_d;
            fault_q        <= fault_d;
            fault_pc_q     <= fault_pc_d;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic        first_q, first_d;

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;

    // Saturating counters; the empty first RUN cycle after reset is not a bubble.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_bubbles_d = perf_bubbles_q;
        first_d        = first_q;
        if (out_valid_q && out_ready && (perf_fetched_q != 32'hFFFF_FFFF))
            perf_fetched_d = perf_fetched_q + 32'd1;
        if (state_q == ST_RUN) begin
            first_d = 1'b0;
            if (!out_valid_q && !first_q && (perf_bubbles_q != 32'hFFFF_FFFF))
                perf_bubbles_d = perf_bubbles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
            first_q        <= 1'b1;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_bubbles_q <= perf_bubbles_d;
            first_q        <= first_d;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: ROM model, reset, fetch, stall, redirect, fault, wrap.
// Perf counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    logic [31:0] rom [256];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;
    assign rom_data = rom[rom_addr];

    instr_fetch dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .fault(fault), .fault_pc(fault_pc)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic rdy);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = rdy;
        step();
        rst = 1'b0;
    endtask

    // Full IF/ID view check against a hand-computed expectation.
    task automatic chk_out(input string nm, input logic ev, input logic [31:0] ep,
                           input logic [31:0] ei, input logic [7:0] ea);
        tests++;
        if (out_valid !== ev || out_pc !== ep || out_instr !== ei || rom_addr !== ea ||
            (ev && out_pc_plus4 !== ep + 32'd4)) begin
            $display("FAIL %s: valid=%0b pc=%h instr=%h addr=%0d plus4=%h, want valid=%0b pc=%h instr=%h addr=%0d",
                     nm, out_valid, out_pc, out_instr, rom_addr, out_pc_plus4, ev, ep, ei, ea);
            fails++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        step(); step();
        tests++;
        if (out_valid !== 1'b0 || out_instr !== 32'h13 || out_pc !== 0 || out_pc_plus4 !== 0 ||
            fault !== 1'b0 || fault_pc !== 0 || rom_addr !== 0) begin
            $display("FAIL reset: valid=%0b instr=%h pc=%h p4=%h fault=%0b fpc=%h addr=%0d, want 0/00000013/0/0/0/0/0",
                     out_valid, out_instr, out_pc, out_pc_plus4, fault, fault_pc, rom_addr);
            fails++;
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'h0000_0293; exp_i[1] = 32'h0290_2283;
        exp_i[2] = 32'h0250_2423; exp_i[3] = 32'h07d0_0093;
        do_reset(1'b1);
        tests++;
        if (rom_addr !== 8'd0) begin
            $display("FAIL seq_addr0: addr=%0d want 0", rom_addr); fails++;
        end
        for (int i = 0; i < 4; i++) begin
            step();
            chk_out("seq", 1'b1, 32'(4 * i), exp_i[i], 8'(i + 1));
        end
    endtask

    task automatic test_stall();
        do_reset(1'b0);
        step();
        chk_out("stall_first_ignores_ready", 1'b1, 32'h0, rom[0], 8'd1);
        out_ready = 1'b1;
        step();
        chk_out("stall_pre", 1'b1, 32'h4, 32'h0290_2283, 8'd2);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall_hold", 1'b1, 32'h4, 32'h0290_2283, 8'd2);
        end
        out_ready = 1'b1;
        step();
        chk_out("stall_release", 1'b1, 32'h8, 32'h0250_2423, 8'd3);
    endtask

    task automatic test_redirect_and_fault();
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) step();
        chk_out("redir_pre", 1'b1, 32'hC, 32'h07d0_0093, 8'd4);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk_out("redir_bubble", 1'b0, 32'hC, 32'h13, 8'd8);
        step();
        chk_out("redir_target", 1'b1, 32'h20, rom[8], 8'd9);
        step();
        chk_out("redir_next", 1'b1, 32'h24, rom[9], 8'd10);
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step();
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h22 || out_valid !== 1'b0 || rom_addr !== 8'd10) begin
            $display("FAIL misalign: fault=%0b fpc=%h valid=%0b addr=%0d, want 1/00000022/0/10",
                     fault, fault_pc, out_valid, rom_addr);
            fails++;
        end
        redirect_pc = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (fault !== 1'b1 || fault_pc !== 32'h22 || out_valid !== 1'b0 || rom_addr !== 8'd10) begin
                $display("FAIL halt_hold: fault=%0b fpc=%h valid=%0b addr=%0d, want 1/00000022/0/10",
                         fault, fault_pc, out_valid, rom_addr);
                fails++;
            end
        end
        redirect_valid = 1'b0;
        do_reset(1'b1);
        tests++;
        if (fault !== 1'b0 || fault_pc !== 0 || rom_addr !== 0 || out_valid !== 1'b0) begin
            $display("FAIL fault_clear: fault=%0b fpc=%h addr=%0d valid=%0b, want 0/0/0/0",
                     fault, fault_pc, rom_addr, out_valid);
            fails++;
        end
        step();
        chk_out("restart", 1'b1, 32'h0, 32'h0000_0293, 8'd1);
    endtask

    task automatic test_wrap_alias();
        do_reset(1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h3FC;
        step();
        redirect_valid = 1'b0;
        chk_out("alias_bubble", 1'b0, 32'h0, 32'h13, 8'd255);
        step();
        chk_out("alias_3fc", 1'b1, 32'h3FC, rom[255], 8'd0);
        step();
        chk_out("alias_400", 1'b1, 32'h400, 32'h0000_0293, 8'd1);
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC || out_pc_plus4 !== 32'h0 ||
            out_instr !== rom[255] || rom_addr !== 8'd0) begin
            $display("FAIL wrap: valid=%0b pc=%h p4=%h instr=%h addr=%0d, want 1/fffffffc/0/%h/0",
                     out_valid, out_pc, out_pc_plus4, out_instr, rom_addr, rom[255]);
            fails++;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(1'b1);
        step(); step(); step();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        step();
        chk_out("midrst", 1'b0, 32'h0, 32'h13, 8'd0);
`ifdef FETCH_PERF_CNT_EN
        tests++;
        if (perf_fetched !== 0 || perf_bubbles !== 0) begin
            $display("FAIL midrst_perf: fetched=%0d bubbles=%0d want 0/0", perf_fetched, perf_bubbles);
            fails++;
        end
`endif
        rst = 1'b0; redirect_valid = 1'b0;
        step();
        chk_out("midrst_restart", 1'b1, 32'h0, 32'h0000_0293, 8'd1);
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        logic [31:0] ef [8];
        logic [31:0] eb [8];
        ef = '{0, 1, 2, 3, 3, 4, 5, 5};
        eb = '{0, 0, 0, 0, 1, 1, 1, 1};
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            redirect_valid = (i == 3 || i == 6);
            redirect_pc    = (i == 6) ? 32'h41 : 32'h20;
            step();
            tests++;
            if (perf_fetched !== ef[i] || perf_bubbles !== eb[i]) begin
                $display("FAIL perf[%0d]: fetched=%0d bubbles=%0d want %0d/%0d",
                         i, perf_fetched, perf_bubbles, ef[i], eb[i]);
                fails++;
            end
        end
        redirect_valid = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | 32'(i);
        rom[0] = 32'h0000_0293; rom[1] = 32'h0290_2283;
        rom[2] = 32'h0250_2423; rom[3] = 32'h07d0_0093;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_and_fault();
        test_wrap_alias();
        test_reset_midstream();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
